mux_select_sequencer: RTL
=========================

Name: mux_select_sequencer

Overview:
- Upstream control stage for the 4:1 multiplexer; each channel's result comes back on F.
- Steps the mux select S through every channel with a programmable dwell time.
- Samples the returned F for each channel and reassembles the channel bits into a parallel word.
- Also emits each sampled bit as a serial stream; used to scan or serialize the mux inputs under clock control.

Parameters:
- SEL_W, 2, select width driven to the mux.
- N_IN, 4, channel count; must equal 2**SEL_W.
- HOLD, 1, cycles S is held per channel before F is sampled; must be ≥1.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  begin sweep; honoured only in IDLE.
- MODE  input  1  0 = single sweep, 1 = continuous sweeps; sampled with START.
- STOP  input  1  abort request.
- F  input  1  mux output for the channel currently selected by S.
- S  output  SEL_W  select to the mux, registered.
- SAMPLE  output  N_IN  last completed sweep; bit i = F sampled while S addressed channel i.
- SAMPLE_VALID  output  1  one-cycle pulse when SAMPLE updates.
- BIT_OUT  output  1  most recent sampled F, registered.
- BIT_VALID  output  1  one-cycle pulse per BIT_OUT update.
- BUSY  output  1  high outside IDLE.

Behaviour:
- Reset: S=0, SAMPLE=0, SAMPLE_VALID=0, BIT_OUT=0, BIT_VALID=0, BUSY=0, state IDLE, shadow register=0, dwell counter=0.
- RST mid-sweep aborts identically; partial data is discarded.
- States and transitions:
  - IDLE: waits for START.
  - IDLE → DWELL on START && !STOP:
    - S=channel 0, dwell counter loads HOLD-1, MODE latched.
  - DWELL, counter decrementing to 0; in the cycle counter==0:
    - F captured into shadow[ch], BIT_OUT<=F, BIT_VALID pulses next cycle.
    - If ch != N_IN-1: S advances to next channel, counter reloads.
  - After capturing the last channel:
    - SAMPLE <= shadow including the just-captured bit; SAMPLE_VALID pulses next cycle.
    - Latched MODE=0: → IDLE, S returns to 0.
    - Latched MODE=1: S wraps to channel 0, counter reloads, stays DWELL with no idle gap.
- Latency: START sampled at edge t.
  - S=0 from t+1.
  - Channel k captured at edge t+(k+1)*HOLD.
  - SAMPLE_VALID high in cycle t+N_IN*HOLD+1.
  - One sweep occupies N_IN*HOLD cycles.
- F is assumed combinational from S; no extra settle cycle beyond HOLD.
- STOP rules:
  - STOP in DWELL: next state IDLE, S=0, no SAMPLE_VALID; SAMPLE keeps its previous value.
  - STOP in the same cycle as a last-channel capture: the capture completes and SAMPLE_VALID pulses, then → IDLE.
  - START and STOP together in IDLE: STOP wins, remain IDLE.
- START while BUSY is ignored; MODE changes mid-sweep are ignored.
- Channel counter is SEL_W bits and wraps naturally from N_IN-1 to 0.

Optional Feature:
- Macro: MUX_SEQ_GRAY_EN.
- Defined: S steps in Gray order (2-bit: 00,01,11,10), so exactly one select bit toggles per step, minimising mux glitches.
  - Internal channel counter stays binary; S = counter ^ (counter>>1).
  - SAMPLE bit index is still the channel number (the Gray value of S), so SAMPLE content is identical to binary mode.
  - BIT_OUT order follows Gray order.
- Undefined: S steps in binary order 0..N_IN-1.

Decomposition:
- Package mux_seq_pkg holds:
  - state enum {IDLE, DWELL}.
  - Constants SEL_W_DEF=2, N_IN_DEF=4, HOLD_DEF=1.
  - Function bin2gray.
- One sub-module, mux_dwell_counter: loadable down-counter with inputs load and load value HOLD-1, and output zero flag; width $clog2(HOLD+1).

Test Plan:
1. Pair with multiplexer, A=4'b0101, HOLD=1, MODE=0, START pulse:
   - S = 0,1,2,3 on consecutive cycles.
   - BIT_OUT = 1,0,1,0.
   - SAMPLE=4'b0101 with a single SAMPLE_VALID pulse 5 cycles after START; BUSY then drops.
2. HOLD=3, A=4'b1100:
   - Each S value held exactly 3 cycles.
   - SAMPLE=4'b1100 at cycle 13 after START.
   - Exactly 4 BIT_VALID pulses.
3. MODE=1, A=4'b0011, then A changed to 4'b1010 mid second sweep:
   - Back-to-back SAMPLE_VALID pulses every 4 cycles.
   - Sweep 1 gives 4'b0011.
   - The first sweep fully after the change gives 4'b1010.
   - S wraps 3→0 with no gap.
4. STOP asserted at S=2; separately, RST asserted at S=1:
   - Next cycle IDLE with S=0.
   - No SAMPLE_VALID; SAMPLE retains the prior value (0 after RST).
   - START held during BUSY has no effect.
5. START and STOP asserted together in IDLE → stays IDLE, BUSY=0.
   - STOP in the last-channel capture cycle → SAMPLE_VALID still pulses.
6. With MUX_SEQ_GRAY_EN defined, A=4'b0101:
   - S sequence 00,01,11,10, one bit toggling per step.
   - BIT_OUT=1,0,0,1.
   - SAMPLE=4'b0101.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux select sequencer.
package mux_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam int SEL_W_DEF = 2;
  localparam int N_IN_DEF  = 4;
  localparam int HOLD_DEF  = 1;
  localparam int GRAY_W    = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/mux_select_sequencer_dwell.sv
// mux_dwell_counter: loadable down-counter timing how long S dwells on a channel.
module mux_dwell_counter #(
  parameter  int HOLD = 1,
  localparam int CW   = $clog2(HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Count down to zero and park there until reloaded
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {CW{1'b0}}) begin
      cnt <= cnt - CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {CW{1'b0}});

endmodule

// File: rtl/mux_select_sequencer.sv
// Sweeps the 4:1 mux select, samples F per channel into SAMPLE and a serial BIT_OUT.
// Define MUX_SEQ_GRAY_EN to step S in Gray order instead of binary.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int N_IN  = N_IN_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic             STOP,
  input  logic             F,
  output logic [SEL_W-1:0] S,
  output logic [N_IN-1:0]  SAMPLE,
  output logic             SAMPLE_VALID,
  output logic             BIT_OUT,
  output logic             BIT_VALID,
  output logic             BUSY
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0]    LOAD_VAL = CW'(HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_IN - 1);

  state_t           state;
  logic [SEL_W-1:0] ch;
  logic             mode_lat;
  logic [N_IN-1:0]  shadow;
  logic [N_IN-1:0]  shadow_next;

  logic zero;
  logic last;
  logic go_start;
  logic do_cap;
  logic stay;
  logic abort;
  logic cnt_load;
  logic cnt_clr;

  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] c);
`ifdef MUX_SEQ_GRAY_EN
    return SEL_W'(bin2gray(GRAY_W'(c)));
`else
    return c;
`endif
  endfunction

  mux_dwell_counter #(.HOLD(HOLD)) u_dwell (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .clr      (cnt_clr),
    .load_val (LOAD_VAL),
    .zero     (zero)
  );

  // A last-channel capture always completes, even when STOP arrives with it
  assign last     = (ch == LAST_CH);
  assign go_start = (state == IDLE) && START && !STOP;
  assign do_cap   = (state == DWELL) && zero && (!STOP || last);
  assign stay     = do_cap && !(last && (!mode_lat || STOP));
  assign abort    = (state == DWELL) && STOP && !(zero && last);
  assign cnt_load = go_start || stay;
  assign cnt_clr  = abort || (do_cap && !stay);

  // Shadow word with the bit currently on F merged in at the select position
  always_comb begin
    shadow_next    = shadow;
    shadow_next[S] = F;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      ch           <= {SEL_W{1'b0}};
      S            <= {SEL_W{1'b0}};
      mode_lat     <= 1'b0;
      shadow       <= {N_IN{1'b0}};
      SAMPLE       <= {N_IN{1'b0}};
      SAMPLE_VALID <= 1'b0;
      BIT_OUT      <= 1'b0;
      BIT_VALID    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      BIT_VALID    <= 1'b0;
      case (state)
        IDLE: begin
          if (go_start) begin
            state    <= DWELL;
            ch       <= {SEL_W{1'b0}};
            S        <= sel_of({SEL_W{1'b0}});
            mode_lat <= MODE;
            BUSY     <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        DWELL: begin
          if (abort) begin
            state <= IDLE;
            ch    <= {SEL_W{1'b0}};
            S     <= {SEL_W{1'b0}};
            BUSY  <= 1'b0;
          end else if (do_cap) begin
            shadow    <= shadow_next;
            BIT_OUT   <= F;
            BIT_VALID <= 1'b1;
            ch        <= ch + SEL_W'(1);
            S         <= sel_of(ch + SEL_W'(1));
            if (last) begin
              SAMPLE       <= shadow_next;
              SAMPLE_VALID <= 1'b1;
            end else begin
              SAMPLE <= SAMPLE;
            end
            if (stay) begin
              state <= DWELL;
              BUSY  <= 1'b1;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            state <= DWELL;
          end
        end
        default: begin
          state <= IDLE;
          ch    <= {SEL_W{1'b0}};
          S     <= {SEL_W{1'b0}};
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
